// File: rtl/stoch_pkg.sv
// Shared sizing and FSM encoding for the stochastic bitstream decoder.
package stoch_pkg;
    localparam int INWD    = 8;
    localparam int DIM_OUT = 8;
    localparam int WIN     = 2 ** INWD;
    localparam int CNTW    = INWD + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;
endpackage

// File: rtl/stoch_lane_cnt.sv
// One lane: counts ones over a window and latches the window total on load.
module stoch_lane_cnt
    import stoch_pkg::*;
#(
    parameter int LANE_W = CNTW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    input  logic              load,
    output logic [LANE_W-1:0] count
);

    logic [LANE_W-1:0] acc;

    // load folds the final beat into the result so the window total needs no extra cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            count <= acc + LANE_W'(inc);
            acc   <= '0;
        end else if (inc) begin
            acc <= acc + LANE_W'(1);
        end
    end

endmodule

// File: rtl/stoch_decode.sv
// Stochastic-to-binary decoder: counts ones per lane over 2**INWD accepted beats.
module stoch_decode
    import stoch_pkg::state_t;
    import stoch_pkg::IDLE;
    import stoch_pkg::ACC;
#(
    parameter int DIM_OUT = stoch_pkg::DIM_OUT,
    parameter int INWD    = stoch_pkg::INWD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          cont,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIM_OUT-1:0]            bit_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIM_OUT-1:0][INWD:0]    out_cnt,
    output logic                          busy
);

    localparam int CNTW = INWD + 1;

    state_t           state;
    state_t           state_nxt;
    logic [INWD-1:0]  win_cnt;
    logic             at_last;
    logic             accept;
    logic             last_beat;

    assign at_last   = &win_cnt;
    assign accept    = in_valid && in_ready && !clr;
    assign last_beat = accept && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ACC;
                ACC:     if (last_beat && !cont) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Hold off the final beat while an unconsumed result would otherwise be overwritten
    always_comb begin
        busy     = (state == ACC);
        in_ready = (state == ACC) && !(at_last && out_valid && !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      win_cnt <= '0;
        else if (clr)    win_cnt <= '0;
        else if (accept) win_cnt <= win_cnt + INWD'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         out_valid <= 1'b0;
        else if (last_beat) out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    for (genvar k = 0; k < DIM_OUT; k++) begin : g_lane
        stoch_lane_cnt #(
            .LANE_W(CNTW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (accept && bit_in[k]),
            .clr   (clr),
            .load  (last_beat),
            .count (out_cnt[k])
        );
    end

endmodule

// File: tb/tb_stoch_decode.sv
// Directed bench for stoch_decode with a window-queue reference model.
module tb_stoch_decode;

    localparam int DIM  = 8;
    localparam int INWD = 8;
    localparam int WIN  = 256;
    localparam int CNTW = 9;

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    logic start     = 1'b0;
    logic cont      = 1'b0;
    logic clr       = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b1;
    logic [DIM-1:0] bit_in = '0;
    logic in_ready;
    logic out_valid;
    logic busy;
    logic [DIM-1:0][CNTW-1:0] out_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stoch_decode #(
        .DIM_OUT (DIM),
        .INWD    (INWD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_in    (bit_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keep the beats of the open window, sum per lane when it fills
    logic [DIM-1:0] m_q[$];
    bit m_acc = 1'b0;
    bit m_ov  = 1'b0;
    int m_cnt[DIM];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_acc = 1'b0;
            m_ov  = 1'b0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
        end else begin
            bit rdy;
            bit ld;
            rdy = m_acc && !(m_q.size() == WIN - 1 && m_ov && !out_ready);
            ld  = 1'b0;
            if (clr) begin
                m_q.delete();
                m_acc = 1'b0;
            end else if (m_acc) begin
                if (in_valid && rdy) begin
                    m_q.push_back(bit_in);
                    if (m_q.size() == WIN) begin
                        foreach (m_cnt[k]) begin
                            m_cnt[k] = 0;
                            foreach (m_q[b]) m_cnt[k] += int'(m_q[b][k]);
                        end
                        m_q.delete();
                        ld = 1'b1;
                        if (!cont) m_acc = 1'b0;
                    end
                end
            end else if (start) begin
                m_acc = 1'b1;
            end
            if (ld) m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = m_acc && !(m_q.size() == WIN - 1 && m_ov && !out_ready);
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_acc));
        for (int k = 0; k < DIM; k++)
            check($sformatf("out_cnt[%0d]", k), 32'(out_cnt[k]), 32'(m_cnt[k]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [DIM-1:0] pattern(input int mode, input logic [DIM-1:0] pat, input int b);
        logic [DIM-1:0] r;
        if (mode == 0) return pat;
        for (int k = 0; k < DIM; k++) r[k] = (b < 64 * k);
        return r;
    endfunction

    // Offer beats until n are accepted; returns just after the edge of the last accept
    task automatic beats(input int n, input int mode, input logic [DIM-1:0] pat, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        while (got < n && cyc < 4 * n + 50) begin
            bit_in   = pattern(mode, pat, got);
            in_valid = toggle ? ph : 1'b1;
            ph       = !ph;
            @(negedge clk);
            if (in_valid && in_ready && !clr) got++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("beat_budget", 32'(got), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt0", 32'(out_cnt[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full window of all-ones, single shot
        cont = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        beats(256, 0, 8'hFF, 1'b0);
        check("t1_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < DIM; k++) check("t1_cnt", 32'(out_cnt[k]), 32'd256);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_model", 32'(m_cnt[7]), 32'd256);
        tick();
        check("t1_drain", 32'(out_valid), 32'd0);

        // Lane k high on the first 64*k beats
        pulse_start();
        beats(256, 1, 8'h00, 1'b0);
        check("t2_lane0", 32'(out_cnt[0]), 32'd0);
        check("t2_lane1", 32'(out_cnt[1]), 32'd64);
        check("t2_lane2", 32'(out_cnt[2]), 32'd128);
        check("t2_lane3", 32'(out_cnt[3]), 32'd192);
        check("t2_lane4", 32'(out_cnt[4]), 32'd256);
        tick();

        // Back-to-back windows with a stalled consumer
        cont = 1'b1;
        pulse_start();
        beats(256, 0, 8'hA5, 1'b0);
        out_ready = 1'b0;
        check("t3_w1_valid", 32'(out_valid), 32'd1);
        check("t3_stay_acc", 32'(busy), 32'd1);
        beats(255, 0, 8'h3C, 1'b0);
        cont     = 1'b0;
        bit_in   = 8'h3C;
        in_valid = 1'b1;
        check("t3_stall", 32'(in_ready), 32'd0);
        check("t3_hold0", 32'(out_cnt[0]), 32'd256);
        check("t3_hold1", 32'(out_cnt[1]), 32'd0);
        repeat (3) tick();
        check("t3_stall_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("t3_release", 32'(in_ready), 32'd1);
        beats(1, 0, 8'h3C, 1'b0);
        check("t3_w2_valid", 32'(out_valid), 32'd1);
        check("t3_w2_lane2", 32'(out_cnt[2]), 32'd256);
        check("t3_w2_lane0", 32'(out_cnt[0]), 32'd0);
        check("t3_w2_idle", 32'(busy), 32'd0);
        tick();

        // Half-rate in_valid: windows count beats, not cycles
        pulse_start();
        beats(256, 0, 8'h01, 1'b1);
        check("t4_lane0", 32'(out_cnt[0]), 32'd256);
        check("t4_lane1", 32'(out_cnt[1]), 32'd0);
        repeat (20) tick();
        check("t4_single", 32'(out_valid), 32'd0);

        // Abort mid-window, then a fresh window
        pulse_start();
        beats(100, 0, 8'hFF, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        bit_in   = 8'hFF;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_prior0", 32'(out_cnt[0]), 32'd256);
        check("t5_prior1", 32'(out_cnt[1]), 32'd0);
        pulse_start();
        beats(256, 0, 8'h0F, 1'b0);
        check("t5_lane0", 32'(out_cnt[0]), 32'd256);
        check("t5_lane3", 32'(out_cnt[3]), 32'd256);
        check("t5_lane4", 32'(out_cnt[4]), 32'd0);
        tick();

        // Asynchronous reset mid-window
        pulse_start();
        beats(200, 0, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cnt0", 32'(out_cnt[0]), 32'd0);
        check("t6_cnt3", 32'(out_cnt[3]), 32'd0);
        repeat (2) tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        bit_in   = 8'hFF;
        repeat (300) tick();
        in_valid = 1'b0;
        check("t6_no_result", 32'(out_valid), 32'd0);
        check("t6_stay_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
